// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the generation scheduler.
package gen_scheduler_pkg;

  localparam int SPEED_MAX   = 15;
  localparam int FRAME_CNT_W = 4;

  typedef logic [3:0] speed_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN,
    SWAP_WAIT
  } sched_state_t;

endpackage

// File: rtl/gen_scheduler_frame_pacer.sv
// Counts rendered frames since the last generation start and flags when the next one is due.
module frame_pacer
  import gen_scheduler_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  speed_t                 speed_in,
  input  logic                   render_done_in,
  input  logic                   clear_in,
  output logic [FRAME_CNT_W-1:0] frame_cnt_out,
  output logic                   due_out
);

  localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = '1;

  logic [FRAME_CNT_W:0] period;

  // Period follows speed_in combinationally so a speed change applies at once.
  assign period  = (FRAME_CNT_W + 1)'(SPEED_MAX + 1) - {1'b0, speed_in};
  assign due_out = (speed_in != '0) && ({1'b0, frame_cnt_out} >= period);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt_out <= '0;
    end else if (clear_in) begin
      frame_cnt_out <= '0;
    end else if (render_done_in && (frame_cnt_out != FRAME_MAX)) begin
      frame_cnt_out <= frame_cnt_out + 1'b1;
    end
  end

endmodule

// File: rtl/gen_scheduler.sv
// Paces Game of Life generations against display frames; swaps buffers only on frame boundaries.
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  speed_t           speed_in,
  input  logic             step_in,
  input  logic             clear_overrun_in,
  input  logic             render_done_in,
  input  logic             logic_done_in,
  input  logic             buf_ready_in,
  output logic             logic_start_out,
  output logic             buf_swap_out,
  output logic             busy_out,
  output logic             overrun_out,
  output logic [CNT_W-1:0] gen_count_out,
  output sched_state_t     state_out
);

  // Handshakes: every *_done_in, step_in and clear_overrun_in is a one-cycle
  // strobe sampled on posedge clk_in; buf_ready_in is a level that qualifies a
  // swap only in a render_done_in cycle; logic_start_out and buf_swap_out are
  // registered one-cycle pulses issued one cycle after their qualifying event.

  sched_state_t           state;
  logic                   due;
  logic                   launch;
  logic                   overrun_set;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  assign launch      = (state == WAIT) && (due || ((speed_in == '0) && step_in));
  assign overrun_set = ((state == RUN) || (state == SWAP_WAIT)) && due;
  assign state_out   = state;

  frame_pacer u_frame_pacer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .speed_in       (speed_in),
    .render_done_in (render_done_in),
    .clear_in       (launch),
    .frame_cnt_out  (frame_cnt),
    .due_out        (due)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      logic_start_out <= 1'b0;
      buf_swap_out    <= 1'b0;
      busy_out        <= 1'b0;
      overrun_out     <= 1'b0;
      gen_count_out   <= '0;
    end else begin
      logic_start_out <= 1'b0;
      buf_swap_out    <= 1'b0;

      if (overrun_set) begin
        overrun_out <= 1'b1;
      end else if (clear_overrun_in) begin
        overrun_out <= 1'b0;
      end

      case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          // busy stays up through the swap pulse cycle and drops one later
          busy_out <= launch;
          if (launch) begin
            state           <= RUN;
            logic_start_out <= 1'b1;
          end
        end
        RUN: begin
          if (logic_done_in) state <= SWAP_WAIT;
        end
        SWAP_WAIT: begin
          if (render_done_in && buf_ready_in) begin
            state         <= WAIT;
            buf_swap_out  <= 1'b1;
            gen_count_out <= gen_count_out + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  wire unused_frame_cnt = ^frame_cnt;

endmodule
